// File: rtl/param_pipe_pkg.sv
// -----------------------------------------------------------------------------
// param_pipe_pkg
// Shared constants and helpers for the param_pipe elastic pipeline.
//   MAX_DEPTH : largest supported number of register stages
//   clog2_p1  : bits needed to hold the values 0..n (occupancy counter width)
// Data is an untyped WIDTH-bit vector, so no typedefs live here.
// -----------------------------------------------------------------------------
package param_pipe_pkg;

    localparam int MAX_DEPTH = 16;

    // Number of bits required to represent every value in 0..n, minimum 1.
    function automatic int clog2_p1(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : param_pipe_pkg

// File: rtl/param_pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One valid/data register slice of the elastic pipeline.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear of the valid bit (data holds)
//   up_valid, up_data   : beat offered by the upstream stage / producer
//   dn_ready            : downstream can take this stage's beat this cycle
//   v, d                : registered valid and data of this stage
//   rdy                 : this stage can load a new beat this cycle
// -----------------------------------------------------------------------------
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // An empty stage always accepts; a full one only if its beat moves on.
    assign rdy = !v_q || dn_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (rdy) begin
            v_d = up_valid;
            // Data only changes on a real beat so an idle output keeps the
            // last delivered value.
            if (up_valid) begin
                d_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule : pipe_stage

// File: rtl/param_pipe.sv
// -----------------------------------------------------------------------------
// param_pipe
// Parametrised elastic pipeline of DEPTH register slices with valid/ready
// backpressure, an occupancy counter and a synchronous flush. With BYPASS=1
// the block collapses to wires.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data   : producer side handshake and data
//   out_valid, out_ready, out_data: consumer side handshake and data
//   flush                         : synchronous clear of all stages
//   count                         : number of valid stages (0..DEPTH)
// -----------------------------------------------------------------------------
module param_pipe
    import param_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0,
    localparam int CNT_W = clog2_p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    if (WIDTH < 1) begin : g_bad_width
        $error("param_pipe: WIDTH must be at least 1");
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("param_pipe: DEPTH out of range 1..16");
    end

    if (BYPASS != 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
        assign count     = '0;

        // No state exists in this branch; clock, reset and flush are inert.
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst_n, flush};
    end else begin : g_pipe
        logic [DEPTH-1:0]            v;
        logic [DEPTH-1:0][WIDTH-1:0] d;
        logic [DEPTH-1:0]            rdy;

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             up_v;
            logic [WIDTH-1:0] up_d;
            logic             dn_rdy;

            if (gi == 0) begin : g_head
                assign up_v = in_valid;
                assign up_d = in_data;
            end else begin : g_body
                assign up_v = v[gi-1];
                assign up_d = d[gi-1];
            end

            // Downstream readiness flattened from the valid bits: some later
            // stage is empty or the consumer drains. Equivalent to chaining
            // the stage rdy outputs, without a self-referencing vector.
            if (gi == DEPTH - 1) begin : g_tail
                assign dn_rdy = out_ready;
            end else begin : g_mid
                assign dn_rdy = out_ready | ~(&v[DEPTH-1:gi+1]);
            end

            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .up_valid (up_v),
                .up_data  (up_d),
                .dn_ready (dn_rdy),
                .v        (v[gi]),
                .d        (d[gi]),
                .rdy      (rdy[gi])
            );
        end

        assign in_ready  = rdy[0];
        assign out_valid = v[DEPTH-1];
        assign out_data  = d[DEPTH-1];

        // Only the head stage's ready leaves the block.
        logic unused_rdy;
        assign unused_rdy = ^rdy;

        logic             in_hs, out_hs;
        logic [CNT_W-1:0] count_q, count_d;

        assign in_hs  = in_valid & in_ready;
        assign out_hs = out_valid & out_ready;

        always_comb begin
            count_d = count_q;
            if (flush) begin
                count_d = '0;
            end else if (in_hs && !out_hs) begin
                count_d = count_q + CNT_W'(1);
            end else if (!in_hs && out_hs) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign count = count_q;
    end

endmodule : param_pipe

// File: tb/tb_param_pipe.sv
// -----------------------------------------------------------------------------
// tb_param_pipe
// Four param_pipe instances share clk/rst_n:
//   u_a : WIDTH=16 DEPTH=3   (stream, flush, mid-stream reset)
//   u_b : WIDTH=8  DEPTH=4   (backpressure fill and resume)
//   u_c : defaults (8, 2)    (push and pop while full)
//   u_d : BYPASS=1           (combinational passthrough)
// Expected beats are queued on input handshakes and popped on output
// handshakes; occupancy is tracked by an independent counter per instance.
// -----------------------------------------------------------------------------
module tb_param_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A ----------------
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_count, a_cnt_m;
    logic [15:0] q_a[$];
    int          a_pops;

    param_pipe #(.WIDTH(16), .DEPTH(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush), .count(a_count)
    );

    // ---------------- instance B ----------------
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_count, b_cnt_m;
    logic [7:0]  q_b[$];
    logic        b_rdy_s;
    int          b_pops;

    param_pipe #(.WIDTH(8), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush), .count(b_count)
    );

    // ---------------- instance C ----------------
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [7:0]  c_in_data, c_out_data;
    logic [1:0]  c_count, c_cnt_m;
    logic [7:0]  q_c[$];

    param_pipe u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .flush(c_flush), .count(c_count)
    );

    // ---------------- instance D (bypass) ----------------
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_flush;
    logic [7:0]  d_in_data, d_out_data;
    logic [1:0]  d_count;

    param_pipe #(.WIDTH(8), .BYPASS(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .flush(d_flush), .count(d_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // One clock cycle on A: drive at negedge, sample #1 later, score, advance.
    task automatic cyc_a(input logic vin, input logic [15:0] dat, input logic ordy);
        logic [15:0] exp_d;
        logic        ihs, ohs;
        a_in_valid = vin; a_in_data = dat; a_out_ready = ordy;
        #1;
        ihs = a_in_valid & a_in_ready;
        ohs = a_out_valid & a_out_ready;
        checks++;
        if (a_count !== a_cnt_m) begin
            errors++;
            $display("FAIL a_count actual=%0d required=%0d", a_count, a_cnt_m);
        end
        if (ohs) begin
            checks++;
            a_pops++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_beat actual=%h required=none", a_out_data);
            end else begin
                exp_d = q_a.pop_front();
                $display("a beat out data=%h", a_out_data);
                if (a_out_data !== exp_d) begin
                    errors++;
                    $display("FAIL a_data actual=%h required=%h", a_out_data, exp_d);
                end
            end
        end
        if (a_flush) begin
            q_a.delete();
            a_cnt_m = 2'd0;
        end else begin
            if (ihs) q_a.push_back(dat);
            a_cnt_m = a_cnt_m + 2'(ihs) - 2'(ohs);
        end
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic vin, input logic [7:0] dat, input logic ordy);
        logic [7:0] exp_d;
        logic       ihs, ohs;
        b_in_valid = vin; b_in_data = dat; b_out_ready = ordy;
        #1;
        b_rdy_s = b_in_ready;
        ihs = b_in_valid & b_in_ready;
        ohs = b_out_valid & b_out_ready;
        checks++;
        if (b_count !== b_cnt_m) begin
            errors++;
            $display("FAIL b_count actual=%0d required=%0d", b_count, b_cnt_m);
        end
        if (ohs) begin
            checks++;
            b_pops++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_beat actual=%h required=none", b_out_data);
            end else begin
                exp_d = q_b.pop_front();
                $display("b beat out data=%h", b_out_data);
                if (b_out_data !== exp_d) begin
                    errors++;
                    $display("FAIL b_data actual=%h required=%h", b_out_data, exp_d);
                end
            end
        end
        if (ihs) q_b.push_back(dat);
        b_cnt_m = b_cnt_m + 3'(ihs) - 3'(ohs);
        @(negedge clk);
    endtask

    task automatic cyc_c(input logic vin, input logic [7:0] dat, input logic ordy);
        logic [7:0] exp_d;
        logic       ihs, ohs;
        c_in_valid = vin; c_in_data = dat; c_out_ready = ordy;
        #1;
        ihs = c_in_valid & c_in_ready;
        ohs = c_out_valid & c_out_ready;
        checks++;
        if (c_count !== c_cnt_m) begin
            errors++;
            $display("FAIL c_count actual=%0d required=%0d", c_count, c_cnt_m);
        end
        if (ohs) begin
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL c_unexpected_beat actual=%h required=none", c_out_data);
            end else begin
                exp_d = q_c.pop_front();
                $display("c beat out data=%h", c_out_data);
                if (c_out_data !== exp_d) begin
                    errors++;
                    $display("FAIL c_data actual=%h required=%h", c_out_data, exp_d);
                end
            end
        end
        if (ihs) q_c.push_back(dat);
        c_cnt_m = c_cnt_m + 2'(ihs) - 2'(ohs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_count !== 2'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a actual=v%b d%h c%0d r%b required=v0 d0000 c0 r1",
                     a_out_valid, a_out_data, a_count, a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h0 || b_count !== 3'd0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b actual=v%b d%h c%0d r%b required=v0 d00 c0 r1",
                     b_out_valid, b_out_data, b_count, b_in_ready);
        end
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 8'h0 || c_count !== 2'd0 || c_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_c actual=v%b d%h c%0d r%b required=v0 d00 c0 r1",
                     c_out_valid, c_out_data, c_count, c_in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_stream();
        logic [15:0] vals [3];
        logic        exp_v;
        logic [1:0]  peak;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        peak = 2'd0;
        for (int i = 0; i < 8; i++) begin
            cyc_a(i < 3, (i < 3) ? vals[i] : 16'h0, 1'b1);
            exp_v = (i + 1 >= 3) && (i + 1 <= 5);
            if (a_count > peak) peak = a_count;
            checks++;
            if (a_out_valid !== exp_v) begin
                errors++;
                $display("FAIL stream_valid edge=%0d actual=%b required=%b", i + 1, a_out_valid, exp_v);
            end
        end
        checks++;
        if (peak !== 2'd3) begin
            errors++;
            $display("FAIL stream_peak actual=%0d required=3", peak);
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL stream_drain actual=%0d required=0", q_a.size());
        end
    endtask

    task automatic test_backpressure();
        int p0;
        for (int i = 0; i < 6; i++) begin
            cyc_b(1'b1, 8'h10 + 8'(i), 1'b0);
            checks++;
            if (b_rdy_s !== (i < 4)) begin
                errors++;
                $display("FAIL bp_fill_ready cycle=%0d actual=%b required=%b", i, b_rdy_s, (i < 4));
            end
        end
        checks++;
        if (b_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_full_count actual=%0d required=4", b_count);
        end
        for (int i = 0; i < 3; i++) begin
            p0 = b_pops;
            cyc_b(1'b1, 8'h20 + 8'(i), 1'b1);
            checks++;
            if (b_rdy_s !== 1'b1 || b_pops != p0 + 1) begin
                errors++;
                $display("FAIL bp_resume cycle=%0d actual=r%b pops%0d required=r1 pops%0d",
                         i, b_rdy_s, b_pops - p0, 1);
            end
        end
        for (int i = 0; i < 6; i++) cyc_b(1'b0, 8'h00, 1'b1);
        checks++;
        if (q_b.size() != 0 || b_count !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain actual=q%0d c%0d required=q0 c0", q_b.size(), b_count);
        end
    endtask

    task automatic test_back_to_back();
        cyc_c(1'b1, 8'hA1, 1'b0);
        cyc_c(1'b1, 8'hA2, 1'b0);
        checks++;
        if (c_count !== 2'd2) begin
            errors++;
            $display("FAIL full_count actual=%0d required=2", c_count);
        end
        for (int i = 0; i < 3; i++) begin
            cyc_c(1'b1, 8'hB0 + 8'(i), 1'b1);
            checks++;
            if (c_count !== 2'd2) begin
                errors++;
                $display("FAIL pushpop_count cycle=%0d actual=%0d required=2", i, c_count);
            end
        end
        for (int i = 0; i < 4; i++) cyc_c(1'b0, 8'h00, 1'b1);
        checks++;
        if (q_c.size() != 0 || c_count !== 2'd0) begin
            errors++;
            $display("FAIL pushpop_drain actual=q%0d c%0d required=q0 c0", q_c.size(), c_count);
        end
    endtask

    task automatic test_flush();
        int p0;
        cyc_a(1'b1, 16'h4444, 1'b0);
        cyc_a(1'b1, 16'h5555, 1'b0);
        checks++;
        if (a_count !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre_count actual=%0d required=2", a_count);
        end
        a_flush = 1'b1;
        cyc_a(1'b1, 16'h6666, 1'b0);
        a_flush = 1'b0;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear actual=c%0d v%b required=c0 v0", a_count, a_out_valid);
        end
        p0 = a_pops;
        for (int i = 0; i < 5; i++) cyc_a(1'b0, 16'h0, 1'b1);
        checks++;
        if (a_pops != p0) begin
            errors++;
            $display("FAIL flush_leak actual=%0d required=0", a_pops - p0);
        end
    endtask

    task automatic test_async_reset();
        cyc_a(1'b1, 16'h7777, 1'b1);
        cyc_a(1'b1, 16'h8888, 1'b1);
        cyc_a(1'b1, 16'h9999, 1'b1);
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_count !== 2'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset actual=v%b d%h c%0d r%b required=v0 d0000 c0 r1",
                     a_out_valid, a_out_data, a_count, a_in_ready);
        end
        q_a.delete(); q_b.delete(); q_c.delete();
        a_cnt_m = 2'd0; b_cnt_m = 3'd0; c_cnt_m = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a(1'b1, 16'h00AB, 1'b1);
        for (int k = 2; k <= 4; k++) begin
            checks++;
            if (a_out_valid !== (k - 1 == 3)) begin
                errors++;
                $display("FAIL post_reset_valid edge=%0d actual=%b required=%b", k - 1, a_out_valid, (k - 1 == 3));
            end
            cyc_a(1'b0, 16'h0, 1'b1);
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL post_reset_drain actual=%0d required=0", q_a.size());
        end
    endtask

    task automatic test_bypass();
        d_in_data = 8'h5A; d_in_valid = 1'b1; d_out_ready = 1'b1; d_flush = 1'b0;
        #1;
        checks++;
        if (d_out_data !== 8'h5A || d_out_valid !== 1'b1 || d_in_ready !== 1'b1 || d_count !== 2'd0) begin
            errors++;
            $display("FAIL bypass_pass actual=d%h v%b r%b c%0d required=d5a v1 r1 c0",
                     d_out_data, d_out_valid, d_in_ready, d_count);
        end
        d_in_data = 8'hC3; d_out_ready = 1'b0; d_flush = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (d_out_data !== 8'hC3 || d_in_ready !== 1'b0 || d_count !== 2'd0) begin
            errors++;
            $display("FAIL bypass_stall actual=d%h r%b c%0d required=dc3 r0 c0",
                     d_out_data, d_in_ready, d_count);
        end
        d_in_valid = 1'b0;
        #1;
        checks++;
        if (d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle actual=%b required=0", d_out_valid);
        end
        d_flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_flush = 0; a_cnt_m = 0; a_pops = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_flush = 0; b_cnt_m = 0; b_pops = 0;
        c_in_valid = 0; c_in_data = 0; c_out_ready = 0; c_flush = 0; c_cnt_m = 0;
        d_in_valid = 0; d_in_data = 0; d_out_ready = 1; d_flush = 0;
        b_rdy_s = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_param_pipe
